// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side sequencer for the single-clock simple dual-port RAM.
// On an accepted start it walks a contiguous address range through the RAM read
// port and delivers the returned words as a valid/ready stream. A 2-entry FIFO
// absorbs the one-cycle registered read latency plus one word of backpressure
// slack, and a credit check on issue keeps that FIFO from overflowing.
module ram_stream_reader #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          length,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [MEM_WIDTH-1:0] mem_data,
  output logic                 out_valid,
  output logic [MEM_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Address walks the RAM modulo its depth, so a run may wrap past the top.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    if (a == AW'(MEM_DEPTH - 1)) begin
      return '0;
    end
    return a + AW'(1);
  endfunction

  // Issue is allowed only while the words already owed to the FIFO
  // (stored plus the one in flight, minus the one leaving now) stay below two.
  function automatic logic credit_ok(input logic [1:0] count, input logic inflight,
                                     input logic leaving);
    logic [2:0] owed;
    owed = {1'b0, count} + {2'b00, inflight};
    return owed < (3'd2 + {2'b00, leaving});
  endfunction

  logic [AW-1:0]        addr_q;
  logic [AW:0]          issue_rem;
  logic [AW:0]          deliver_rem;
  logic                 zero_run;
  logic                 start_ok;
  logic                 issue;
  logic                 pop;

  // Stage p1: a read was issued last cycle, so mem_data carries a word now.
  logic                 vld_p1;

  // Stage p2: FIFO storage holding returned words until the consumer takes them.
  logic [MEM_WIDTH-1:0] fifo_p2 [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_count;

  assign start_ok = (state == IDLE) && start;
  assign pop      = out_valid && out_ready;
  assign issue    = (state == READ) && (issue_rem != '0) &&
                    credit_ok(fifo_count, vld_p1, pop);

  assign mem_en    = issue;
  assign mem_addr  = addr_q;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_p2[rd_ptr];
  assign out_last  = out_valid && (deliver_rem == (AW+1)'(1));
  assign done      = (state == DONE);
  // A zero-length run reports busy during its single DONE cycle; normal runs
  // drop busy in the same cycle that done pulses.
  assign busy      = (state == READ) || (state == DRAIN) ||
                     ((state == DONE) && zero_run);

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue && (issue_rem == (AW+1)'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((deliver_rem == '0) ||
            (pop && (deliver_rem == (AW+1)'(1)))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register, run counters and FIFO bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      issue_rem   <= '0;
      deliver_rem <= '0;
      zero_run    <= 1'b0;
      vld_p1      <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= issue;
      if (start_ok) begin
        addr_q      <= base_addr;
        issue_rem   <= length;
        deliver_rem <= length;
        zero_run    <= (length == '0);
      end else begin
        if (issue) begin
          addr_q    <= next_addr(addr_q);
          issue_rem <= issue_rem - (AW+1)'(1);
        end
        if (pop) begin
          deliver_rem <= deliver_rem - (AW+1)'(1);
        end
      end
      if (vld_p1) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({vld_p1, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO data capture of the word returned by the RAM.
  always_ff @(posedge clock) begin
    if (vld_p1) begin
      fifo_p2[wr_ptr] <= mem_data;
    end
  end

endmodule
